result_axi_writer: RTL and testbench

//  AXI4-Lite initiator that pushes each vchess attack/check evaluation into PS memory. On every is_attacking_done

---
 rtl/vchess_axi_pkg.sv | 46 ++++
 rtl/axil_single_write.sv | 67 ++++++
 rtl/result_axi_writer.sv | 209 ++++++++++++++++++++
 tb/tb_result_axi_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vchess_axi_pkg.sv
// Shared constants, FSM states and status-word layout for the vchess AXI4-Lite result writer.
package vchess_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int REPORT_WORDS = 5;

    localparam logic [2:0] WORD_WHITE_LO = 3'd0;
    localparam logic [2:0] WORD_WHITE_HI = 3'd1;
    localparam logic [2:0] WORD_BLACK_LO = 3'd2;
    localparam logic [2:0] WORD_BLACK_HI = 3'd3;
    localparam logic [2:0] WORD_STATUS   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP,
        ST_DONE
    } wr_state_t;

    localparam int SF_WCHK = 0;
    localparam int SF_BCHK = 1;
    localparam int SF_ERR  = 2;
    localparam int SF_OVR  = 8;
    localparam int SF_SEQ  = 16;

    function automatic logic [31:0] status_word(
        input logic [15:0] seq,
        input logic [7:0]  ovr,
        input logic        err,
        input logic        bchk,
        input logic        wchk
    );
        logic [31:0] w;
        w             = '0;
        w[SF_SEQ +: 16] = seq;
        w[SF_OVR +: 8]  = ovr;
        w[SF_ERR]     = err;
        w[SF_BCHK]    = bchk;
        w[SF_WCHK]    = wchk;
        return w;
    endfunction

endpackage

// File: rtl/axil_single_write.sv
// One AXI4-Lite write: AW and W issued together, each dropped after its own handshake, then B wait.
module axil_single_write #(
    parameter int ADDR_WIDTH = 40
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic                  o_addr_done,
    output logic                  o_ack,
    output logic [1:0]            o_resp,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [31:0]           o_wdata,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready
);

    logic                  r_aw;
    logic                  r_w;
    logic                  r_b;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    assign w_aw_hs = r_aw & i_awready;
    assign w_w_hs  = r_w & i_wready;

    // Address phase ends on the cycle the last outstanding channel handshakes
    assign o_addr_done = (r_aw | r_w) & (~r_aw | i_awready) & (~r_w | i_wready);
    assign o_ack       = r_b & i_bvalid;
    assign o_resp      = i_bresp;

    assign o_awaddr  = r_addr;
    assign o_awvalid = r_aw;
    assign o_wdata   = r_data;
    assign o_wvalid  = r_w;
    assign o_bready  = r_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_aw   <= 1'b0;
            r_w    <= 1'b0;
            r_b    <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (w_aw_hs) r_aw <= 1'b0;
            if (w_w_hs) r_w <= 1'b0;
            if (o_addr_done) r_b <= 1'b1;
            if (o_ack) r_b <= 1'b0;
            if (i_req) begin
                r_aw   <= 1'b1;
                r_w    <= 1'b1;
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/result_axi_writer.sv
// Pushes each attack/check evaluation to PS memory as five AXI4-Lite writes, status word last.
// Optional VCHESS_RESULT_IRQ_EN adds an irq pulse after the status write completes.
module result_axi_writer
    import vchess_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 40,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 40'h00_A001_0000,
    parameter int                    OVR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [63:0]           white_is_attacking,
    input  logic [63:0]           black_is_attacking,
    input  logic                  white_in_check,
    input  logic                  black_in_check,
    input  logic                  is_attacking_done,
`ifdef VCHESS_RESULT_IRQ_EN
    output logic                  irq,
`endif
    output logic                  busy,
    output logic                  wr_error,
    output logic [ADDR_WIDTH-1:0] res_axi_awaddr,
    output logic [2:0]            res_axi_awprot,
    output logic                  res_axi_awvalid,
    input  logic                  res_axi_awready,
    output logic [31:0]           res_axi_wdata,
    output logic [3:0]            res_axi_wstrb,
    output logic                  res_axi_wvalid,
    input  logic                  res_axi_wready,
    input  logic [1:0]            res_axi_bresp,
    input  logic                  res_axi_bvalid,
    output logic                  res_axi_bready
);

    wr_state_t             r_state;
    wr_state_t             w_state_nxt;
    logic [2:0]            r_k;
    logic [2:0]            w_next_k;
    logic [63:0]           r_snap_wa;
    logic [63:0]           r_snap_ba;
    logic                  r_snap_wchk;
    logic                  r_snap_bchk;
    logic [63:0]           r_shad_wa;
    logic [63:0]           r_shad_ba;
    logic                  r_shad_wchk;
    logic                  r_shad_bchk;
    logic                  r_pending;
    logic [OVR_WIDTH-1:0]  r_overrun;
    logic [15:0]           r_seq;
    logic                  r_wr_error;
    logic [63:0]           w_src_wa;
    logic [63:0]           w_src_ba;
    logic                  w_req;
    logic                  w_launch_in;
    logic                  w_launch_sh;
    logic                  w_addr_done;
    logic                  w_ack;
    logic                  w_last_ack;
    logic                  w_err_nxt;
    logic [1:0]            w_resp;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [31:0]           w_req_data;

    assign w_launch_sh = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && r_pending;
    assign w_launch_in = (r_state == ST_IDLE) && !r_pending && is_attacking_done;
    assign w_last_ack  = w_ack && (r_k == WORD_STATUS);
    assign w_err_nxt   = r_wr_error | (w_ack && (w_resp != AXI_RESP_OKAY));

    // Word 0 of a new report is issued on the launch edge, before the snapshot registers
    assign w_src_wa = w_launch_sh ? r_shad_wa :
                      w_launch_in ? white_is_attacking : r_snap_wa;
    assign w_src_ba = w_launch_sh ? r_shad_ba :
                      w_launch_in ? black_is_attacking : r_snap_ba;

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_next_k    = r_k;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_launch_sh || w_launch_in) begin
                    w_state_nxt = ST_ADDR;
                    w_req       = 1'b1;
                    w_next_k    = WORD_WHITE_LO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_addr_done) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_ack) begin
                    if (r_k == WORD_STATUS) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ADDR;
                        w_req       = 1'b1;
                        w_next_k    = r_k + 3'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_data = '0;
        case (w_next_k)
            WORD_WHITE_LO: w_req_data = w_src_wa[31:0];
            WORD_WHITE_HI: w_req_data = w_src_wa[63:32];
            WORD_BLACK_LO: w_req_data = w_src_ba[31:0];
            WORD_BLACK_HI: w_req_data = w_src_ba[63:32];
            WORD_STATUS:   w_req_data = status_word(r_seq + 16'd1, 8'(r_overrun),
                                                    w_err_nxt, r_snap_bchk, r_snap_wchk);
            default:       w_req_data = '0;
        endcase
    end

    assign w_req_addr = BASE_ADDR + ADDR_WIDTH'({w_next_k, 2'b00});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_snap_wa   <= '0;
            r_snap_ba   <= '0;
            r_snap_wchk <= 1'b0;
            r_snap_bchk <= 1'b0;
            r_shad_wa   <= '0;
            r_shad_ba   <= '0;
            r_shad_wchk <= 1'b0;
            r_shad_bchk <= 1'b0;
            r_pending   <= 1'b0;
            r_overrun   <= '0;
            r_seq       <= '0;
            r_wr_error  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_next_k;
            r_wr_error <= w_err_nxt;
            if (w_last_ack) r_seq <= r_seq + 16'd1;
            if (w_launch_in) begin
                r_snap_wa   <= white_is_attacking;
                r_snap_ba   <= black_is_attacking;
                r_snap_wchk <= white_in_check;
                r_snap_bchk <= black_in_check;
            end
            if (w_launch_sh) begin
                r_snap_wa   <= r_shad_wa;
                r_snap_ba   <= r_shad_ba;
                r_snap_wchk <= r_shad_wchk;
                r_snap_bchk <= r_shad_bchk;
                r_pending   <= 1'b0;
            end
            // One result is held back; any further arrival is counted and lost
            if (is_attacking_done && !w_launch_in) begin
                if (!r_pending) begin
                    r_pending   <= 1'b1;
                    r_shad_wa   <= white_is_attacking;
                    r_shad_ba   <= black_is_attacking;
                    r_shad_wchk <= white_in_check;
                    r_shad_bchk <= black_in_check;
                end else if (r_overrun != {OVR_WIDTH{1'b1}}) begin
                    r_overrun <= r_overrun + OVR_WIDTH'(1);
                end
            end
        end
    end

`ifdef VCHESS_RESULT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!reset_n) r_irq <= 1'b0;
        else          r_irq <= w_last_ack;
    end

    assign irq = r_irq;
`endif

    assign busy           = (r_state != ST_IDLE);
    assign wr_error       = r_wr_error;
    assign res_axi_awprot = 3'b000;
    assign res_axi_wstrb  = 4'hF;

    axil_single_write #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_req      (w_req),
        .i_addr     (w_req_addr),
        .i_data     (w_req_data),
        .o_addr_done(w_addr_done),
        .o_ack      (w_ack),
        .o_resp     (w_resp),
        .o_awaddr   (res_axi_awaddr),
        .o_awvalid  (res_axi_awvalid),
        .i_awready  (res_axi_awready),
        .o_wdata    (res_axi_wdata),
        .o_wvalid   (res_axi_wvalid),
        .i_wready   (res_axi_wready),
        .i_bresp    (res_axi_bresp),
        .i_bvalid   (res_axi_bvalid),
        .o_bready   (res_axi_bready)
    );

endmodule

// File: tb/tb_result_axi_writer.sv
// Directed bench for result_axi_writer: report layout, handshakes, overrun, errors, reset, irq.
module tb_result_axi_writer;

    localparam logic [39:0] BASE = 40'h00_A001_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] white = '0;
    logic [63:0] black = '0;
    logic        wchk = 1'b0;
    logic        bchk = 1'b0;
    logic        done = 1'b0;
    logic        busy;
    logic        wr_error;
    logic [39:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
`ifdef VCHESS_RESULT_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_axi_writer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .white_is_attacking(white),
        .black_is_attacking(black),
        .white_in_check    (wchk),
        .black_in_check    (bchk),
        .is_attacking_done (done),
`ifdef VCHESS_RESULT_IRQ_EN
        .irq               (irq),
`endif
        .busy              (busy),
        .wr_error          (wr_error),
        .res_axi_awaddr    (awaddr),
        .res_axi_awprot    (awprot),
        .res_axi_awvalid   (awvalid),
        .res_axi_awready   (awready),
        .res_axi_wdata     (wdata),
        .res_axi_wstrb     (wstrb),
        .res_axi_wvalid    (wvalid),
        .res_axi_wready    (wready),
        .res_axi_bresp     (bresp),
        .res_axi_bvalid    (bvalid),
        .res_axi_bready    (bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        done    = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic [63:0] wa, input logic [63:0] ba,
                         input logic wc, input logic bc);
        white = wa;
        black = ba;
        wchk  = wc;
        bchk  = bc;
        done  = 1'b1;
        @(negedge clk);
        done  = 1'b0;
        white = ~wa;
        black = ~ba;
        wchk  = ~wc;
        bchk  = ~bc;
    endtask

    task automatic beat_addr(input string tag, input logic [39:0] ea,
                             input logic [31:0] ed, input int awd);
        int c;
        bit aw_ok;
        bit w_ok;
        c = 0;
        aw_ok = 1'b0;
        w_ok = 1'b0;
        while (!awvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk({tag, " awvalid"}, awvalid, 1);
        c = 0;
        while (!(aw_ok && w_ok) && c < 20) begin
            awready = !aw_ok && (c >= awd);
            wready  = !w_ok;
            chk({tag, " bready idle"}, bready, 0);
`ifdef VCHESS_RESULT_IRQ_EN
            chk({tag, " irq idle"}, irq, 0);
`endif
            if (!aw_ok) begin
                chk({tag, " awvalid held"}, awvalid, 1);
                chk({tag, " awaddr"}, awaddr, ea);
            end else begin
                chk({tag, " awvalid dropped"}, awvalid, 0);
            end
            if (!w_ok) begin
                chk({tag, " wvalid held"}, wvalid, 1);
                chk({tag, " wdata"}, wdata, ed);
            end else begin
                chk({tag, " wvalid dropped"}, wvalid, 0);
            end
            if (awvalid && awready) aw_ok = 1'b1;
            if (wvalid && wready) w_ok = 1'b1;
            @(negedge clk);
            c++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk({tag, " aw+w taken"}, {aw_ok, w_ok}, 2'b11);
    endtask

    task automatic beat_resp(input string tag, input logic [1:0] resp,
                             input int bd, input bit last);
        repeat (bd) begin
            chk({tag, " bready wait"}, bready, 1);
            chk({tag, " no new aw"}, awvalid, 0);
            chk({tag, " no new w"}, wvalid, 0);
            @(negedge clk);
        end
        chk({tag, " bready"}, bready, 1);
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk({tag, " bready drop"}, bready, 0);
`ifdef VCHESS_RESULT_IRQ_EN
        chk({tag, " irq"}, irq, last);
`endif
        if (last) chk({tag, " busy in done"}, busy, 1);
    endtask

    task automatic report(input string tag, input logic [63:0] wa, input logic [63:0] ba,
                          input logic [31:0] st, input int awd, input logic [1:0] r2);
        logic [31:0] d [5];
        d[0] = wa[31:0];
        d[1] = wa[63:32];
        d[2] = ba[31:0];
        d[3] = ba[63:32];
        d[4] = st;
        for (int k = 0; k < 5; k++) begin
            beat_addr($sformatf("%s w%0d", tag, k), BASE + 40'(4 * k), d[k], awd);
            beat_resp($sformatf("%s w%0d", tag, k), (k == 2) ? r2 : 2'b00,
                      (awd > 0) ? 2 : 0, k == 4);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst busy", busy, 0);
        chk("rst wr_error", wr_error, 0);
        chk("rst awvalid", awvalid, 0);
        chk("rst wvalid", wvalid, 0);
        chk("rst bready", bready, 0);
        chk("awprot", awprot, 3'b000);
        chk("wstrb", wstrb, 4'hF);
`ifdef VCHESS_RESULT_IRQ_EN
        chk("rst irq", irq, 0);
`endif

        // 1: ready slave, basic layout and 1-cycle latency
        repeat (3) @(negedge clk);
        chk("t1 idle no aw", awvalid, 0);
        pulse(64'h0000_0010_0000_FF00, 64'h0, 1'b0, 1'b0);
        chk("t1 latency awvalid", awvalid, 1);
        chk("t1 busy", busy, 1);
        report("t1", 64'h0000_0010_0000_FF00, 64'h0, 32'h0001_0000, 0, 2'b00);
        @(negedge clk);
        chk("t1 idle busy", busy, 0);
`ifdef VCHESS_RESULT_IRQ_EN
        chk("t1 irq single", irq, 0);
`endif

        // 2: awready delayed 3 cycles, B delayed
        do_reset();
        pulse(64'h1234_5678_9ABC_DEF0, 64'h8100_0000_0000_0081, 1'b1, 1'b1);
        report("t2", 64'h1234_5678_9ABC_DEF0, 64'h8100_0000_0000_0081,
               32'h0001_0003, 3, 2'b00);

        // 3: three pulses 2 cycles apart, third dropped
        do_reset();
        pulse(64'h1, 64'h2, 1'b0, 1'b0);
        @(negedge clk);
        pulse(64'h0000_0003_0000_0004, 64'h0000_0005_0000_0006, 1'b0, 1'b1);
        @(negedge clk);
        pulse(64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE, 1'b1, 1'b1);
        report("t3a", 64'h1, 64'h2, 32'h0001_0100, 0, 2'b00);
        report("t3b", 64'h0000_0003_0000_0004, 64'h0000_0005_0000_0006,
               32'h0002_0102, 0, 2'b00);
        repeat (3) @(negedge clk);
        chk("t3 dropped busy", busy, 0);
        chk("t3 dropped aw", awvalid, 0);

        // 4: SLVERR on word 2, sticky until reset
        do_reset();
        pulse(64'hA5A5_0000_0000_5A5A, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b0);
        report("t4a", 64'hA5A5_0000_0000_5A5A, 64'h0F0F_0F0F_F0F0_F0F0,
               32'h0001_0004, 0, 2'b10);
        chk("t4 wr_error set", wr_error, 1);
        pulse(64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        report("t4b", 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000,
               32'h0002_0005, 0, 2'b00);
        chk("t4 wr_error sticky", wr_error, 1);
        do_reset();
        chk("t4 wr_error cleared", wr_error, 0);

        // 5: reset while waiting for B of word 3
        pulse(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
        beat_addr("t5 w0", BASE, 32'h3333_4444, 0);
        beat_resp("t5 w0", 2'b00, 0, 1'b0);
        beat_addr("t5 w1", BASE + 40'h4, 32'h1111_2222, 0);
        beat_resp("t5 w1", 2'b00, 0, 1'b0);
        beat_addr("t5 w2", BASE + 40'h8, 32'h7777_8888, 0);
        beat_resp("t5 w2", 2'b00, 0, 1'b0);
        beat_addr("t5 w3", BASE + 40'hC, 32'h5555_6666, 0);
        chk("t5 in resp", bready, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5 rst awvalid", awvalid, 0);
        chk("t5 rst wvalid", wvalid, 0);
        chk("t5 rst bready", bready, 0);
        chk("t5 rst busy", busy, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5 abandoned", awvalid, 0);
        pulse(64'h0000_0000_DEAD_BEEF, 64'h0000_CAFE_0000_0000, 1'b1, 1'b0);
        report("t5r", 64'h0000_0000_DEAD_BEEF, 64'h0000_CAFE_0000_0000,
               32'h0001_0001, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
